// File: rtl/wifi_uart_pkg.sv
// rtl/wifi_uart_pkg.sv - shared FSM encoding, frame constants and baud divisor helper
package wifi_uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/wifi_tx_fifo.sv
// rtl/wifi_tx_fifo.sv - synchronous byte FIFO feeding the UART transmitter
module wifi_tx_fifo
    import wifi_uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wifi_uart_tx.sv
// rtl/wifi_uart_tx.sv - 8N1 UART transmitter driving TXD toward the WiFi module
// Defining WIFI_TX_FIFO_EN adds an input FIFO and back-to-back frames.
module wifi_uart_tx
    import wifi_uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);
    localparam int              DIV       = calc_div(CLK_HZ, BAUD);
    localparam int              CW        = $clog2(DIV);
    localparam logic [CW-1:0]   BAUD_LAST = CW'(DIV - 1);
    localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("wifi_uart_tx: CLK_HZ/BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wifi_uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          bit_done;
    logic          accept;
    logic          load;
    logic [7:0]    load_data;

    assign bit_done = (baud_cnt == BAUD_LAST);
    assign accept   = tx_valid && tx_ready;

`ifdef WIFI_TX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    wifi_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (tx_data),
        .pop       (load),
        .pop_data  (load_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tx_ready = !fifo_full;
    assign busy     = (state != ST_IDLE) || !fifo_empty;
    // Reloading at the end of STOP keeps queued frames gap-free.
    assign load     = !fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && bit_done));
`else
    assign tx_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign load      = accept;
    assign load_data = tx_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            baud_cnt <= (state == ST_IDLE || bit_done) ? '0 : baud_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        shift <= load_data;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == BIT_LAST) state <= ST_STOP;
                    end
                end
                default: begin
                    if (bit_done) begin
                        if (load) begin
                            shift <= load_data;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Line level follows the state one cycle later so txd stays a clean flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd <= 1'b1;
        end else begin
            case (state)
                ST_START: txd <= 1'b0;
                ST_DATA:  txd <= shift[0];
                default:  txd <= 1'b1;
            endcase
        end
    end

endmodule
